// File: rtl/mpmc10_pkg.sv
// Shared types and constants for the mpmc10 memory controller read-response path.
package mpmc10_pkg;

   typedef enum logic [3:0] {
      IDLE         = 4'd0,
      PRESET1      = 4'd1,
      PRESET2      = 4'd2,
      WRITE_DATA0  = 4'd3,
      WRITE_DATA1  = 4'd4,
      WRITE_DATA2  = 4'd5,
      WRITE_DATA3  = 4'd6,
      READ_DATA0   = 4'd7,
      READ_DATA1   = 4'd8,
      READ_DATA2   = 4'd9,
      WAIT_NACK    = 4'd10,
      WRITE_TRAMP  = 4'd11,
      WRITE_TRAMP1 = 4'd12
   } mpmc10_state_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_HOLD = 2'd2
   } mpmc10_asm_state_t;

   localparam int MPMC10_STRIP_WIDTH = 128;

   // Index of the last strip actually captured: bursts longer than the buffer are truncated.
   function automatic logic [5:0] clamp_last(input logic [5:0] num_strips, input int max_strips);
      if (num_strips >= 6'(max_strips))
         return 6'(max_strips - 1);
      return num_strips;
   endfunction

endpackage

// File: rtl/mpmc10_resp_line_buf.sv
// Line buffer: MAX_STRIPS strip registers written one slot at a time, read out as one flat line.
module mpmc10_resp_line_buf #(
   parameter int STRIP_WIDTH = 128,
   parameter int MAX_STRIPS  = 4,
   parameter int IDX_W       = $clog2(MAX_STRIPS)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              we,
   input  logic [IDX_W-1:0]                  idx,
   input  logic [STRIP_WIDTH-1:0]            wdata,
   output logic [STRIP_WIDTH*MAX_STRIPS-1:0] line
);

   logic [STRIP_WIDTH-1:0] mem [MAX_STRIPS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_STRIPS; i++)
            mem[i] <= '0;
      end else if (we) begin
         mem[idx] <= wdata;
      end
   end

   // Slot 0 lands in the least significant strip of the line.
   always_comb begin
      line = '0;
      for (int i = 0; i < MAX_STRIPS; i++)
         line[i*STRIP_WIDTH +: STRIP_WIDTH] = mem[i];
   end

endmodule

// File: rtl/mpmc10_resp_line_asm.sv
// Assembles read strips into a cache line and presents it with a valid/ready handshake.
// Optional watchdog enabled by defining MPMC10_RESP_TIMEOUT_EN.
module mpmc10_resp_line_asm
   import mpmc10_pkg::*;
#(
   parameter int STRIP_WIDTH = MPMC10_STRIP_WIDTH,
   parameter int MAX_STRIPS  = 4,
   parameter int TIMEOUT     = 1023
) (
   input  logic                              clk,
   input  logic                              rst,
   input  mpmc10_state_t                     state,
   input  logic                              rd_data_valid,
   input  logic [STRIP_WIDTH-1:0]            rd_data,
   input  logic [5:0]                        strip_cnt,
   input  logic [5:0]                        num_strips,
   output logic [STRIP_WIDTH*MAX_STRIPS-1:0] line_o,
   output logic                              line_valid,
   input  logic                              line_ready,
   output logic                              overrun,
   output logic                              oversize,
   output logic                              timeout,
   output mpmc10_asm_state_t                 asm_state
);

   localparam int IDX_W = $clog2(MAX_STRIPS);

   if (MAX_STRIPS < 2 || MAX_STRIPS > 32 || (MAX_STRIPS & (MAX_STRIPS - 1)) != 0 ||
       TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_cfg
      $error("mpmc10_resp_line_asm: MAX_STRIPS must be a power of two in 2..32, TIMEOUT in 1..1023");
   end

   mpmc10_asm_state_t cur, nxt;
   logic [5:0] last;
   logic       start, strip_in, strip_last, wr_en, to_hit;

   assign start      = (cur == S_IDLE) && (state == READ_DATA0);
   assign strip_in   = (cur == S_FILL) && rd_data_valid;
   assign strip_last = strip_in && (strip_cnt == last);
   assign wr_en      = strip_in && (strip_cnt <= last);

`ifdef MPMC10_RESP_TIMEOUT_EN
   logic [9:0] wd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wd <= '0;
      else if (start || strip_in)
         wd <= '0;
      else if (cur == S_FILL && wd != 10'h3FF)
         wd <= wd + 10'd1;
   end

   // Fires on the idle edge that brings the count up to TIMEOUT.
   assign to_hit = (cur == S_FILL) && !rd_data_valid && (wd == 10'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         timeout <= 1'b0;
      else if (to_hit)
         timeout <= 1'b1;
   end
`else
   assign to_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cur <= S_IDLE;
      else
         cur <= nxt;
   end

   // A completing strip wins over a simultaneous abort: the line is whole.
   always_comb begin
      nxt = cur;
      case (cur)
         S_IDLE:  if (state == READ_DATA0) nxt = S_FILL;
         S_FILL:  if (strip_last || to_hit) nxt = S_HOLD;
                  else if (state == IDLE)   nxt = S_IDLE;
         S_HOLD:  if (line_ready) nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // Handshake: line_valid is high exactly in S_HOLD, line_o is frozen while it is high, and the
   // line is consumed on a cycle with line_valid && line_ready; line_ready is ignored otherwise.
   always_comb begin
      line_valid = (cur == S_HOLD);
      asm_state  = cur;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last     <= '0;
         overrun  <= 1'b0;
         oversize <= 1'b0;
      end else begin
         if (start) begin
            last <= clamp_last(num_strips, MAX_STRIPS);
            if (num_strips >= 6'(MAX_STRIPS))
               oversize <= 1'b1;
         end
         if (rd_data_valid && cur != S_FILL)
            overrun <= 1'b1;
      end
   end

   mpmc10_resp_line_buf #(
      .STRIP_WIDTH(STRIP_WIDTH),
      .MAX_STRIPS (MAX_STRIPS),
      .IDX_W      (IDX_W)
   ) u_buf (
      .clk  (clk),
      .rst  (rst),
      .we   (wr_en),
      .idx  (strip_cnt[IDX_W-1:0]),
      .wdata(rd_data),
      .line (line_o)
   );

endmodule

// File: tb/tb_mpmc10_resp_line_asm.sv
// Directed bench for mpmc10_resp_line_asm with a burst-level reference model checked every cycle.
module tb_mpmc10_resp_line_asm;
   import mpmc10_pkg::*;

   localparam int W = 128;
   localparam int N = 4;
`ifdef MPMC10_RESP_TIMEOUT_EN
   localparam int TO = 16;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TO = 1023;
   localparam bit TO_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mpmc10_state_t     state = IDLE;
   logic              rd_data_valid = 1'b0;
   logic [W-1:0]      rd_data = '0;
   logic [5:0]        strip_cnt = '0;
   logic [5:0]        num_strips = '0;
   logic [W*N-1:0]    line_o;
   logic              line_valid;
   logic              line_ready = 1'b0;
   logic              overrun, oversize, timeout;
   mpmc10_asm_state_t asm_state;

   mpmc10_resp_line_asm #(.STRIP_WIDTH(W), .MAX_STRIPS(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .state(state), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
      .strip_cnt(strip_cnt), .num_strips(num_strips), .line_o(line_o), .line_valid(line_valid),
      .line_ready(line_ready), .overrun(overrun), .oversize(oversize), .timeout(timeout),
      .asm_state(asm_state)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] pat(input int k);
      return {4{32'hC0DE_0000 + 32'(k)}};
   endfunction

   // ---------------- reference model ----------------
   // m_ph: 0 waiting for a burst, 1 collecting strips, 2 line on offer.
   int         m_ph = 0;
   int         m_idle = 0;
   logic [5:0] m_last = '0;
   logic [W-1:0] m_slot [N] = '{default: '0};
   bit m_ovr = 0, m_osz = 0, m_to = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph = 0; m_idle = 0; m_last = '0;
         foreach (m_slot[i]) m_slot[i] = '0;
         m_ovr = 0; m_osz = 0; m_to = 0;
      end else begin
         if (rd_data_valid && m_ph != 1) m_ovr = 1;
         case (m_ph)
            0: if (state == READ_DATA0) begin
                  m_ph = 1;
                  m_idle = 0;
                  if (num_strips >= N) begin m_osz = 1; m_last = 6'(N - 1); end
                  else m_last = num_strips;
               end
            1: if (rd_data_valid) begin
                  m_idle = 0;
                  if (strip_cnt <= m_last) m_slot[int'(strip_cnt)] = rd_data;
                  if (strip_cnt == m_last) m_ph = 2;
                  else if (state == IDLE) m_ph = 0;
               end else begin
                  m_idle++;
                  if (TO_EN && m_idle == TO) begin m_ph = 2; m_to = 1; end
                  else if (state == IDLE) m_ph = 0;
               end
            default: if (line_ready) m_ph = 0;
         endcase
      end
   end

   // ---------------- scoreboard compare ----------------
   logic [W*N-1:0]    exp_line;
   mpmc10_asm_state_t exp_st;

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) exp_line[i*W +: W] = m_slot[i];
         exp_st = (m_ph == 0) ? S_IDLE : (m_ph == 1) ? S_FILL : S_HOLD;
         chk("cyc_line_o", line_o, exp_line);
         chk("cyc_line_valid", line_valid, m_ph == 2);
         chk("cyc_overrun", overrun, m_ovr);
         chk("cyc_oversize", oversize, m_osz);
         chk("cyc_timeout", timeout, m_to);
         chk("cyc_asm_state", asm_state, exp_st);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_burst(input logic [5:0] ns);
      @(negedge clk);
      state = READ_DATA0;
      num_strips = ns;
      @(negedge clk);
      state = READ_DATA1;
   endtask

   task automatic send_strip(input logic [5:0] c, input logic [W-1:0] d);
      rd_data_valid = 1'b1;
      strip_cnt = c;
      rd_data = d;
      @(negedge clk);
      rd_data_valid = 1'b0;
   endtask

   task automatic accept(input string name);
      int n;
      n = 0;
      while (!line_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!line_valid) begin
         failures++;
         $display("FAIL %s_wait line_valid=0 required=1 within 50 cycles", name);
      end
      line_ready = 1'b1;
      @(negedge clk);
      line_ready = 1'b0;
      chk({name, "_drop"}, line_valid, 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      tick(3);
      chk("rst_line_o", line_o, '0);
      chk("rst_line_valid", line_valid, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_oversize", oversize, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      chk("rst_state", asm_state, S_IDLE);
      rst = 1'b0;
      tick(2);

      // four-strip burst, line visible one cycle after the last strip
      start_burst(6'd3);
      for (int k = 0; k < 4; k++) send_strip(6'(k), pat(k));
      state = IDLE;
      chk("t1_valid", line_valid, 1'b1);
      chk("t1_line", line_o, {pat(3), pat(2), pat(1), pat(0)});
      tick(2);
      chk("t1_hold", line_valid, 1'b1);
      accept("t1");

      // single strip, then a stray strip while holding
      start_burst(6'd0);
      send_strip(6'd0, {16{8'h55}});
      state = IDLE;
      chk("t2_valid", line_valid, 1'b1);
      chk("t2_slot0", line_o[W-1:0], {16{8'h55}});
      chk("t2_ovr_pre", overrun, 1'b0);
      send_strip(6'd5, pat(9));
      chk("t2_overrun", overrun, 1'b1);
      chk("t2_line", line_o, {pat(3), pat(2), pat(1), {16{8'h55}}});
      accept("t2");

      // back-pressure for 20 cycles
      start_burst(6'd3);
      for (int k = 0; k < 4; k++) send_strip(6'(k), pat(10 + k));
      state = IDLE;
      tick(20);
      chk("t3_valid", line_valid, 1'b1);
      chk("t3_line", line_o, {pat(13), pat(12), pat(11), pat(10)});
      accept("t3");

      // abort after two strips, then a clean burst
      start_burst(6'd3);
      send_strip(6'd0, pat(20));
      send_strip(6'd1, pat(21));
      state = IDLE;
      tick(5);
      chk("ab_novalid", line_valid, 1'b0);
      chk("ab_state", asm_state, S_IDLE);
      start_burst(6'd3);
      for (int k = 0; k < 4; k++) send_strip(6'(k), pat(30 + k));
      state = IDLE;
      chk("ab_line", line_o, {pat(33), pat(32), pat(31), pat(30)});
      accept("ab");

      // oversize burst truncated at the buffer depth
      chk("os_pre", oversize, 1'b0);
      start_burst(6'd6);
      for (int k = 0; k < 7; k++) send_strip(6'(k), pat(40 + k));
      state = IDLE;
      chk("os_flag", oversize, 1'b1);
      chk("os_line", line_o, {pat(43), pat(42), pat(41), pat(40)});
      accept("os");

`ifdef MPMC10_RESP_TIMEOUT_EN
      // one strip then silence: partial line offered 16 cycles after the strip
      start_burst(6'd3);
      send_strip(6'd0, pat(50));
      tick(15);
      chk("to_early", line_valid, 1'b0);
      tick(1);
      chk("to_flag", timeout, 1'b1);
      chk("to_valid", line_valid, 1'b1);
      chk("to_line", line_o, {pat(43), pat(42), pat(41), pat(50)});
      state = IDLE;
      accept("to");
`endif

      tick(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mpmc10_resp_line_asm.md
Name: mpmc10_resp_line_asm

Overview:
- Downstream consumer of mpmc10_resp_strip_cnt in the mpmc10 read-response path.
- Captures each memory read strip (rd_data qualified by rd_data_valid) into a line buffer slot selected by strip_cnt.
- Presents the assembled cache line to the port return logic with a valid/ready handshake.
- Flags protocol anomalies: overrun, oversize burst and, optionally, timeout.

Parameters:
- STRIP_WIDTH, 128, bits per memory strip (MIG app data width).
- MAX_STRIPS, 4, line buffer depth in strips; line width = STRIP_WIDTH*MAX_STRIPS.
- TIMEOUT, 1023, cycles allowed between accepted strips (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- state  in  mpmc10_state_t  controller state; values IDLE and READ_DATA0 are used.
- rd_data_valid  in  1  strip valid from memory.
- rd_data  in  STRIP_WIDTH  strip data.
- strip_cnt  in  6  current strip index from mpmc10_resp_strip_cnt.
- num_strips  in  6  index of the last strip (strips in burst = num_strips+1).
- line_o  out  STRIP_WIDTH*MAX_STRIPS  assembled line.
- line_valid  out  1  line_o holds a complete line.
- line_ready  in  1  consumer accepts the line.
- overrun  out  1  sticky: a strip arrived while not capturing.
- oversize  out  1  sticky: num_strips >= MAX_STRIPS was seen at capture start.
- timeout  out  1  sticky; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset (async, rst=1): FSM to S_IDLE; line_o=0, line_valid=0, overrun=0, oversize=0, timeout=0, last register=0.
- FSM states: S_IDLE, S_FILL, S_HOLD, encoded as 2 bits.
- S_IDLE -> S_FILL when state==READ_DATA0.
  - On that entry, last <= min(num_strips, MAX_STRIPS-1).
  - oversize is set if num_strips >= MAX_STRIPS.
- S_FILL, on rd_data_valid: write slot strip_cnt[log2(MAX_STRIPS)-1:0].
  - Writes with strip_cnt > last are discarded; the write slot index never wraps.
- S_FILL, on rd_data_valid with strip_cnt==last: transition to S_HOLD.
  - line_valid=1 on the next cycle, so data is visible 1 cycle after the final strip.
  - This is the same edge on which that strip is written.
- S_FILL, on state==IDLE: abort to S_IDLE.
  - line_valid stays 0; partial data is kept but never presented.
- S_HOLD: line_o is stable.
  - line_valid && line_ready -> S_IDLE; line_valid drops on the next cycle.
  - line_ready is ignored while line_valid=0.
- rd_data_valid in S_HOLD or S_IDLE: data dropped, overrun <= 1.
- Simultaneous line_ready in S_HOLD and state==READ_DATA0: go to S_IDLE first; the new capture begins on the following READ_DATA0 cycle.
  - The controller holds READ_DATA0 at least 1 cycle after issuing reads, so this does not lose a burst.
- Sticky flags clear only on rst.
- Width rule: last is 6 bits; comparisons use the full 6-bit strip_cnt.

Optional Feature:
- Macro: MPMC10_RESP_TIMEOUT_EN.
- Defined:
  - A 10-bit watchdog counter clears on entering S_FILL and on each accepted strip, and increments otherwise while in S_FILL.
  - When it reaches TIMEOUT: timeout <= 1 and the FSM goes to S_HOLD with line_valid=1, presenting the partial line.
  - The counter saturates and does not wrap.
- Not defined: no counter logic; timeout is tied to 0; S_FILL waits indefinitely.

Decomposition:
- mpmc10_pkg holds:
  - mpmc10_state_t (existing).
  - new typedef mpmc10_asm_state_t {S_IDLE, S_FILL, S_HOLD}.
  - constant MPMC10_STRIP_WIDTH=128.
- One sub-module is natural: mpmc10_resp_line_buf.
  - Holds the MAX_STRIPS x STRIP_WIDTH register array with a write enable and index, and a flat read-out.
  - Keeps the FSM file small.

Test Plan:
- num_strips=3; READ_DATA0, then 4 valid strips with strip_cnt 0..3 and data A,B,C,D -> line_valid=1 one cycle after D; line_o={D,C,B,A}; holds until line_ready, then 0 on the next cycle.
- num_strips=0; single strip 0x55..55 -> line_valid after 1 strip, slot0=0x55..55; an extra valid in S_HOLD sets overrun=1 and line_o is unchanged.
- num_strips=3 with line_ready held low for 20 cycles -> line_o stable and line_valid=1 throughout; transition to S_IDLE after line_ready=1.
- Abort: 2 of 4 strips received, then state=IDLE -> no line_valid; the next burst of 4 assembles correctly.
- num_strips=6 with MAX_STRIPS=4 -> oversize=1, capture ends at strip_cnt==3, strips 4..6 discarded.
- MPMC10_RESP_TIMEOUT_EN with TIMEOUT=16; 1 of 4 strips then silence -> timeout=1 and line_valid=1 at 16 cycles after the strip.
